// File: rtl/fft_onboard_stim_chk.sv
// On-board stimulus generator and output checker for the FFT core.
// Define FFT_ONBOARD_SIG_CHK_EN to compare the final signature with i_exp_sig.
module fft_onboard_stim_chk #(
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 25,
  parameter int LEN_LOG2    = 8,
  parameter int NUM_FRAMES  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start_test,
  input  logic [1:0]          i_mode,
  input  logic [DATA_W-1:0]   i_wave_data,
  output logic [2*DATA_W-1:0] o_in_tdata,
  output logic                o_in_tvalid,
  output logic                o_in_tlast,
  input  logic                i_in_tready,
  input  logic [2*OUT_W-1:0]  i_out_tdata,
  input  logic                i_out_tvalid,
  input  logic                i_out_tlast,
  input  logic                i_alm,
  input  logic [31:0]         i_exp_sig,
  output logic                o_busy,
  output logic                o_chk_finished,
  output logic                o_err,
  output logic [3:0]          o_err_code,
  output logic [31:0]         o_signature
);

  localparam int SL = (2*OUT_W + 31) / 32;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] NF = 16'(NUM_FRAMES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic                start_prev_q;
  logic [1:0]          mode_q, mode_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [LEN_LOG2-1:0] tx_idx_q, tx_idx_d;
  logic [LEN_LOG2-1:0] rx_idx_q, rx_idx_d;
  logic [15:0]         tx_frm_q, tx_frm_d;
  logic [15:0]         rx_frm_q, rx_frm_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [DATA_W-1:0]   re_q, re_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [3:0]          err_q, err_d;
  logic [31:0]         sig_q, sig_d;
  logic                fin_q, fin_d;
  logic                erro_q, erro_d;

  logic start_edge, tx_fire, rx_fire;
  logic unused_exp;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [31:0] fold(input logic [2*OUT_W-1:0] d);
    logic [SL*32-1:0] p;
    logic [31:0] r;
    p = '0;
    p[2*OUT_W-1:0] = d;
    r = '0;
    for (int i = 0; i < SL; i++) r = r ^ p[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] beat_re(
    input logic [1:0]          m,
    input logic [LEN_LOG2-1:0] idx,
    input logic [15:0]         l,
    input logic [DATA_W-1:0]   w
  );
    logic [DATA_W-1:0] r;
    unique case (m)
      2'd0: r = DATA_W'(idx);
      2'd1: r = DATA_W'(l);
      2'd2: r = w;
      default: r = (idx == '0) ? (DATA_W'(1) << (DATA_W - 2)) : '0;
    endcase
    return r;
  endfunction

  assign start_edge = i_start_test & ~start_prev_q;
  assign tx_fire    = tvalid_q & i_in_tready;
  assign rx_fire    = (state_q == RUN) & i_out_tvalid;
  assign unused_exp = ^i_exp_sig;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    lfsr_d   = lfsr_q;
    tx_idx_d = tx_idx_q;
    rx_idx_d = rx_idx_q;
    tx_frm_d = tx_frm_q;
    rx_frm_d = rx_frm_q;
    tmo_d    = tmo_q;
    re_d     = re_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    err_d    = err_q;
    sig_d    = sig_q;
    unique case (state_q)
      RUN: begin
        if (tx_fire) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (tlast_q) begin
            tx_idx_d = '0;
            tx_frm_d = tx_frm_q + 16'd1;
          end else begin
            tx_idx_d = tx_idx_q + LEN_LOG2'(1);
          end
          re_d     = beat_re(mode_q, tx_idx_d, lfsr_d, i_wave_data);
          tlast_d  = &tx_idx_d;
          tvalid_d = (tx_frm_d != NF);
        end
        if (rx_fire) begin
          sig_d = {sig_q[30:0], sig_q[31]} ^ fold(i_out_tdata);
          if (i_out_tlast != (&rx_idx_q)) begin
            err_d[0] = 1'b1;
          end else if (i_out_tlast) begin
            rx_idx_d = '0;
            rx_frm_d = rx_frm_q + 16'd1;
          end else begin
            rx_idx_d = rx_idx_q + LEN_LOG2'(1);
          end
        end
        if (i_alm) err_d[2] = 1'b1;
        if (tx_fire | rx_fire) begin
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT_CYC)) err_d[1] = 1'b1;
        end
        if ((err_d[2:0] != 3'b000) || (rx_frm_d == NF)) begin
          state_d  = DONE;
          tvalid_d = 1'b0;
`ifdef FFT_ONBOARD_SIG_CHK_EN
          if ((err_d[2:0] == 3'b000) && (sig_d != i_exp_sig))
            err_d[3] = 1'b1;
`endif
        end
      end
      default: begin
        if (start_edge) begin
          state_d  = RUN;
          mode_d   = i_mode;
          lfsr_d   = SEED;
          tx_idx_d = '0;
          rx_idx_d = '0;
          tx_frm_d = '0;
          rx_frm_d = '0;
          tmo_d    = '0;
          err_d    = '0;
          sig_d    = '0;
          re_d     = beat_re(i_mode, '0, SEED, i_wave_data);
          tvalid_d = (NF != 16'd0);
          tlast_d  = 1'b0;
        end
      end
    endcase
    // Completion flags lag the DONE entry by one cycle
    fin_d  = (state_q == DONE) & (state_d == DONE);
    erro_d = fin_d & (|err_q);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      mode_q       <= '0;
      lfsr_q       <= SEED;
      tx_idx_q     <= '0;
      rx_idx_q     <= '0;
      tx_frm_q     <= '0;
      rx_frm_q     <= '0;
      tmo_q        <= '0;
      re_q         <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      err_q        <= '0;
      sig_q        <= '0;
      fin_q        <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= i_start_test;
      mode_q       <= mode_d;
      lfsr_q       <= lfsr_d;
      tx_idx_q     <= tx_idx_d;
      rx_idx_q     <= rx_idx_d;
      tx_frm_q     <= tx_frm_d;
      rx_frm_q     <= rx_frm_d;
      tmo_q        <= tmo_d;
      re_q         <= re_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      err_q        <= err_d;
      sig_q        <= sig_d;
      fin_q        <= fin_d;
      erro_q       <= erro_d;
    end
  end

  assign o_in_tdata     = {{DATA_W{1'b0}}, re_q};
  assign o_in_tvalid    = tvalid_q;
  assign o_in_tlast     = tlast_q;
  assign o_busy         = (state_q == RUN);
  assign o_chk_finished = fin_q;
  assign o_err          = erro_q;
  assign o_err_code     = err_q;
  assign o_signature    = sig_q;

endmodule

// File: tb/tb_fft_onboard_stim_chk.sv
// Bench for fft_onboard_stim_chk: randomized runs against a behavioural model
// with an echoing FFT stand-in on the result side.
module tb_fft_onboard_stim_chk;

  localparam int LEN   = 256;
  localparam int NF    = 4;
  localparam int TMO   = 1000;
  localparam int BEATS = LEN * NF;
`ifdef FFT_ONBOARD_SIG_CHK_EN
  localparam logic [3:0] SIG_ERR = 4'b1000;
`else
  localparam logic [3:0] SIG_ERR = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  wave;
  logic [15:0] in_tdata;
  logic        in_tvalid, in_tlast;
  logic        in_tready = 1'b1;
  logic [49:0] out_tdata;
  logic        out_tvalid, out_tlast, alm;
  logic [31:0] exp_sig = '0;
  logic        busy, fin, err;
  logic [3:0]  err_code;
  logic [31:0] sig;

  int checks = 0;
  int errors = 0;

`define CHK(tag, o, e) \
  begin \
    checks++; \
    assert ((o) === (e)) else begin \
      errors++; \
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e); \
    end \
  end

  fft_onboard_stim_chk #(
    .DATA_W(8), .OUT_W(25), .LEN_LOG2(8),
    .NUM_FRAMES(NF), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start_test(start),
    .i_mode(mode), .i_wave_data(wave),
    .o_in_tdata(in_tdata), .o_in_tvalid(in_tvalid),
    .o_in_tlast(in_tlast), .i_in_tready(in_tready),
    .i_out_tdata(out_tdata), .i_out_tvalid(out_tvalid),
    .i_out_tlast(out_tlast), .i_alm(alm), .i_exp_sig(exp_sig),
    .o_busy(busy), .o_chk_finished(fin), .o_err(err),
    .o_err_code(err_code), .o_signature(sig)
  );

  always #5 clk = ~clk;

  // Monotonic counters/logs; the initial block only records bases.
  int          tx_acc = 0, rx_sent = 0, tx_base = 0, rx_base = 0;
  int          cyc = 0, last_act = 0, stall_bad = 0;
  logic [16:0] tx_log[$];
  logic [49:0] rx_log[$];
  logic        stall_q = 1'b0;
  logic [16:0] held_q = '0;

  int          bad_at = -1, alm_at = -1, stop_at = 1 << 30;
  logic        echo_en = 1'b0;
  logic        rnd_rdy = 1'b0;
  logic [24:0] salt = '0;

  assign wave = 8'((tx_acc - tx_base) * 37 + 11);

  function automatic logic [49:0] echo_word(input int rel, input logic [7:0] re,
                                            input logic [24:0] s);
    logic [31:0] h;
    h = 32'(rel) * 32'h9E3779B1;
    return {25'(h >> 5) ^ s, 25'(re) * 25'd3};
  endfunction

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [49:0] d);
    return ((s << 1) | (s >> 31)) ^ d[31:0] ^ {14'd0, d[49:32]};
  endfunction

  function automatic logic [31:0] golden_impulse(input logic [24:0] s);
    logic [31:0] g;
    g = '0;
    for (int k = 0; k < BEATS; k++)
      g = sig_step(g, echo_word(k, (k % LEN == 0) ? 8'd64 : 8'd0, s));
    return g;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn && in_tvalid && in_tready) begin
      tx_log.push_back({in_tlast, in_tdata});
      tx_acc <= tx_acc + 1;
    end
    if (rstn && ((in_tvalid && in_tready) || (out_tvalid && busy)))
      last_act <= cyc + 1;
    if (stall_q && in_tvalid && ({in_tlast, in_tdata} != held_q))
      stall_bad <= stall_bad + 1;
    stall_q <= rstn && in_tvalid && !in_tready;
    held_q  <= {in_tlast, in_tdata};
  end

  // FFT stand-in: replays accepted stimulus as result beats with gaps.
  always @(negedge clk) begin
    int rel;
    logic [49:0] w;
    rel = rx_sent - rx_base;
    out_tvalid <= 1'b0;
    out_tlast  <= 1'b0;
    alm        <= 1'b0;
    if (echo_en && (tx_acc - tx_base > rel) && rel < stop_at &&
        $urandom_range(3) != 0) begin
      w = echo_word(rel, tx_log[tx_base + rel][7:0], salt);
      out_tdata  <= w;
      out_tvalid <= 1'b1;
      out_tlast  <= ((rel % LEN) == LEN - 1) != (rel == bad_at);
      alm        <= (rel == alm_at);
      rx_log.push_back(w);
      rx_sent <= rx_sent + 1;
    end
  end

  task automatic start_run(input logic [1:0] m, input bit rnd,
                           input int bad, input int al, input int stop);
    @(negedge clk);
    echo_en   = 1'b0;
    in_tready = 1'b1;
    @(negedge clk);
    tx_base = tx_acc;
    rx_base = rx_sent;
    mode    = m;
    rnd_rdy = rnd;
    bad_at  = bad;
    alm_at  = al;
    stop_at = stop;
    salt    = 25'($urandom);
    @(negedge clk);
    start   = 1'b1;
    echo_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    `CHK("start_busy", busy, 1'b1)
    `CHK("start_tvalid", in_tvalid, 1'b1)
    `CHK("start_errcode", err_code, 4'b0000)
    `CHK("start_fin", fin, 1'b0)
  endtask

  task automatic wait_fin(input int budget);
    int n;
    n = 0;
    while (!fin && n < budget) begin
      @(negedge clk);
      in_tready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
      n++;
    end
    `CHK("run_finished", fin, 1'b1)
  endtask

  task automatic wait_err(input int budget);
    int n;
    n = 0;
    while (err_code == 4'b0000 && n < budget) begin
      @(negedge clk);
      n++;
    end
    `CHK("err_seen", (err_code != 4'b0000), 1'b1)
  endtask

  task automatic check_tx(input int m);
    logic [15:0] l;
    logic [7:0]  re;
    int n, bad;
    l = 16'hACE1;
    bad = 0;
    n = tx_acc - tx_base;
    `CHK("tx_beats", n, BEATS)
    if (n > BEATS) n = BEATS;
    for (int k = 0; k < n; k++) begin
      case (m)
        0: re = 8'(k % LEN);
        1: re = l[7:0];
        2: re = 8'(((k == 0) ? 0 : k - 1) * 37 + 11);
        default: re = (k % LEN == 0) ? 8'd64 : 8'd0;
      endcase
      if (tx_log[tx_base + k] !== {(k % LEN == LEN - 1), 8'h00, re}) bad++;
      l = (l >> 1) | 16'(((l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1) << 15);
    end
    `CHK("tx_sequence", bad, 0)
  endtask

  task automatic check_clean(input int m);
    logic [31:0] g;
    g = '0;
    check_tx(m);
    for (int i = 0; i < BEATS; i++) g = sig_step(g, rx_log[rx_base + i]);
    `CHK("rx_beats", rx_sent - rx_base, BEATS)
    `CHK("clean_errcode", err_code, 4'b0000)
    `CHK("clean_err", err, 1'b0)
    `CHK("clean_busy", busy, 1'b0)
    `CHK("signature", sig, g)
    `CHK("stall_hold", stall_bad, 0)
  endtask

  initial begin
    logic [31:0] g, s0;

    repeat (3) @(negedge clk);
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_fin", fin, 1'b0)
    `CHK("rst_err", err, 1'b0)
    `CHK("rst_errcode", err_code, 4'b0000)
    `CHK("rst_sig", sig, 32'h0)
    `CHK("rst_tx", {in_tvalid, in_tlast, in_tdata}, 18'h0)
    rstn = 1'b1;

    start_run(2'd0, 1'b0, -1, -1, 1 << 30);
    wait_fin(6000);
    check_clean(0);

    start_run(2'd0, 1'b1, -1, -1, 1 << 30);
    wait_fin(8000);
    check_clean(0);

    start_run(2'd1, 1'b1, -1, -1, 1 << 30);
    wait_fin(8000);
    check_clean(1);

    start_run(2'd2, 1'b1, -1, -1, 1 << 30);
    wait_fin(8000);
    check_clean(2);

    start_run(2'd3, 1'b0, -1, -1, 1 << 30);
    g = golden_impulse(salt);
    exp_sig = g;
    wait_fin(6000);
    check_clean(3);
    `CHK("impulse_golden", sig, g)

    start_run(2'd3, 1'b1, -1, -1, 1 << 30);
    exp_sig = golden_impulse(salt) ^ (32'd1 << $urandom_range(31));
    wait_fin(8000);
    `CHK("sig_flip_code", err_code, SIG_ERR)
    `CHK("sig_flip_err", err, (SIG_ERR != 4'b0000))

    start_run(2'd0, 1'b0, 100, -1, 1 << 30);
    wait_err(3000);
    `CHK("tlast_code", err_code, 4'b0001)
    `CHK("tlast_fin_lag", fin, 1'b0)
    `CHK("tlast_busy", busy, 1'b0)
    @(negedge clk);
    `CHK("tlast_fin", fin, 1'b1)
    `CHK("tlast_err", err, 1'b1)
    s0 = sig;
    repeat (20) @(negedge clk);
    `CHK("done_sig_hold", sig, s0)
    `CHK("done_code_hold", err_code, 4'b0001)

    start_run(2'd1, 1'b0, 50, 50, 1 << 30);
    wait_err(3000);
    `CHK("alm_tlast_code", err_code, 4'b0101)

    start_run(2'd0, 1'b0, -1, -1, 300);
    wait_err(5000);
    `CHK("timeout_code", err_code, 4'b0010)
    `CHK("timeout_gap", cyc - last_act, TMO)

    start_run(2'd1, 1'b1, -1, -1, 1 << 30);
    repeat (200) @(negedge clk);
    rstn = 1'b0;
    #1;
    `CHK("mid_rst_busy", busy, 1'b0)
    `CHK("mid_rst_tvalid", in_tvalid, 1'b0)
    `CHK("mid_rst_sig", sig, 32'h0)
    `CHK("mid_rst_code", {fin, err, err_code}, 6'h0)
    @(negedge clk);
    rstn = 1'b1;
    start_run(2'd0, 1'b0, -1, -1, 1 << 30);
    wait_fin(6000);
    check_clean(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
